// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
package dmem_pkg;

  // Access size encoding carried on req_size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  // Controller states: idle (accepting), waiting out latency, presenting response.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Loads below this address return a one-hot probe pattern; stores there are dropped.
  localparam int unsigned PROBE_LIMIT = 32;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-addressed storage split into four byte lanes with per-lane write enables.
// Writes are synchronous; reads are combinational so a load sees the addressed
// word in the same cycle it is accepted.
module dmem_byte_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_lane_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];

      // Write this lane's byte when its enable is set; contents are never reset.
      always_ff @(posedge clk) begin
        if (i_lane_we[gi]) r_lane[i_addr] <= i_wdata[8*gi +: 8];
      end

      assign o_rdata[8*gi +: 8] = r_lane[i_addr];
    end
  endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with a valid/ready request/response interface,
// fixed accept-to-response latency, access-fault detection and an optional
// read-only probe window at the bottom of the address space.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter bit          PROBE_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        req_unsigned,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  CNT_LOAD    = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic        r_live;          // low until the first edge after reset release
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic [32:0] w_last_addr;
  logic        w_probe;
  logic        w_misalign;
  logic        w_oob;
  logic        w_fault;
  logic [3:0]  w_lane_mask;
  logic [3:0]  w_lane_we;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_mem_rdata;
  logic [15:0] w_shift;
  logic [31:0] w_load_data;

  assign w_accept    = req_valid && r_live && (r_state == IDLE);

  // Fault decode: 33-bit end address so accesses near 2^32 cannot wrap into range.
  assign w_last_addr = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
  assign w_probe     = PROBE_EN && (req_addr < 32'(PROBE_LIMIT));
  assign w_misalign  = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign w_oob       = (w_last_addr >= 33'(DEPTH_BYTES));
  assign w_fault     = (req_size == SIZE_ILL) || (!w_probe && (w_misalign || w_oob));

  // Lane mask and replicated store data for the addressed bytes.
  always_comb begin
    w_lane_mask = 4'b0000;
    w_wdata_rep = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        w_lane_mask = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_lane_mask = 4'b0011 << req_addr[1:0];
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: w_lane_mask = 4'b1111;
      default:   w_lane_mask = 4'b0000;
    endcase
  end

  // Stores commit on the accept edge; faulting and probe-window stores write nothing.
  assign w_lane_we = (w_accept && req_we && !w_fault && !w_probe) ? w_lane_mask : 4'b0000;

  dmem_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .i_addr    (req_addr[AW+1:2]),
    .i_lane_we (w_lane_we),
    .i_wdata   (w_wdata_rep),
    .o_rdata   (w_mem_rdata)
  );

  assign w_shift = 16'(w_mem_rdata >> {req_addr[1:0], 3'b000});

  // Little-endian load extraction with optional sign extension.
  always_comb begin
    w_load_data = 32'h0;
    if (w_probe) begin
      w_load_data = 32'h1 << req_addr[4:0];
    end else begin
      case (req_size)
        SIZE_BYTE: w_load_data = req_unsigned ? {24'h0, w_shift[7:0]}
                                              : {{24{w_shift[7]}}, w_shift[7:0]};
        SIZE_HALF: w_load_data = req_unsigned ? {16'h0, w_shift}
                                              : {{16{w_shift[15]}}, w_shift};
        SIZE_WORD: w_load_data = w_mem_rdata;
        default:   w_load_data = 32'h0;
      endcase
    end
  end

  // State, latency counter, out-of-reset flag and captured response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_live  <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_err   <= w_fault;
        r_rdata <= (w_fault || req_we) ? 32'h0 : w_load_data;
      end
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = r_live;
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) w_state_next = RESP;
        else               w_cnt_next   = r_cnt - 2'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic        req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl_mem [DEPTH];

  data_mem_ctrl #(
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT),
    .PROBE_EN    (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_unsigned (req_unsigned),
    .req_size     (req_size),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: computes the response from the access rules and updates the byte image.
  function automatic void model_txn(input bit we, input bit uns, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err);
    int unsigned n;
    longint val;
    rdata = 32'h0;
    err   = 1'b0;
    if (size == 2'b11) begin
      err = 1'b1;
      return;
    end
    n = 1 << size;
    if (addr < 32) begin
      if (!we) rdata = 32'h1 << addr[4:0];
      return;
    end
    if ((addr % n) != 0) err = 1'b1;
    else if (longint'(addr) + longint'(n) > longint'(DEPTH)) err = 1'b1;
    else if (we) begin
      for (int i = 0; i < int'(n); i++) mdl_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < int'(n); i++) val = val | (longint'(mdl_mem[addr + i]) << (8*i));
      if (!uns && n < 4 && val[8*n-1]) val = val - (longint'(1) << (8*n));
      rdata = val[31:0];
    end
  endfunction

  // Drives one request and collects its response. lat counts rising edges from the
  // accept edge (inclusive) to the first edge after which resp_valid is high.
  // stable drops if the response or req_ready moves while the response is held.
  task automatic do_txn(input bit we, input bit uns, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input bit busy_en, input logic [31:0] busy_addr,
                        output logic [31:0] rd, output logic er, output int lat, output bit stable);
    int cnt;
    logic [31:0] rd0;
    logic er0;
    rd = 32'h0; er = 1'b0; lat = -1; stable = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    if (req_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL req_ready_timeout: got %b, want 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_we = we; req_unsigned = uns; req_size = size;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    if (busy_en) begin
      req_we = 1'b1; req_size = 2'b10; req_addr = busy_addr; req_wdata = 32'h5A5A5A5A;
    end else begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      if (req_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); lat++; @(negedge clk);
    end
    if (resp_valid !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL resp_valid_timeout: got %b, want 1", resp_valid);
      req_valid = 1'b0;
      return;
    end
    rd0 = resp_rdata; er0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== er0 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rd = rd0; er = er0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run(input bit we, input bit uns, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] exp_d, output logic exp_e,
                     output logic [31:0] rd, output logic er, output int lat, output bit stable);
    model_txn(we, uns, size, addr, wdata, exp_d, exp_e);
    do_txn(we, uns, size, addr, wdata, hold, 1'b0, 32'h0, rd, er, lat, stable);
    $display("txn we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             we, size, addr, wdata, rd, er, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_unsigned = 1'b0;
    req_size = 2'b10; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL rst_req_ready: got %b, want 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid: got %b, want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_resp_rdata: got %h, want 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_errors++; $display("FAIL rst_resp_err: got %b, want 0", resp_err); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL rel_before_edge_ready: got %b, want 0", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rel_after_edge_ready: got %b, want 1", req_ready); end
    $display("reset test done");
  endtask

  // Fill all non-probe words so later loads read defined data.
  task automatic init_memory();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    for (int a = 32; a < int'(DEPTH); a += 4) begin
      model_txn(1'b1, 1'b0, 2'b10, 32'(a), $urandom, ed, ee);
      do_txn(1'b1, 1'b0, 2'b10, 32'(a), {mdl_mem[a+3], mdl_mem[a+2], mdl_mem[a+1], mdl_mem[a]},
             0, 1'b0, 32'h0, rd, er, lat, st);
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL init_store_err @%h: got %b, want 0", a, er); end
    end
    $display("memory initialised");
  endtask

  task automatic test_store_load();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    run(1'b1, 1'b0, 2'b10, 32'h100, 32'hDEADBEEF, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL t1_store_resp: got %h/%b, want 0/0", rd, er); end
    n_checks++; if (lat !== int'(LAT)) begin n_errors++; $display("FAIL t1_store_latency: got %0d, want %0d", lat, LAT); end
    run(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL t1_load_data: got %h, want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL t1_load_err: got %b, want 0", er); end
    n_checks++; if (lat !== int'(LAT)) begin n_errors++; $display("FAIL t1_load_latency: got %0d, want %0d", lat, LAT); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    run(1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hFFFFFFDE) begin n_errors++; $display("FAIL t2_byte_signed: got %h, want ffffffde", rd); end
    run(1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'h000000DE) begin n_errors++; $display("FAIL t2_byte_unsigned: got %h, want 000000de", rd); end
    run(1'b0, 1'b0, 2'b01, 32'h102, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hFFFFDEAD) begin n_errors++; $display("FAIL t2_half_signed: got %h, want ffffdead", rd); end
    run(1'b0, 1'b1, 2'b01, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'h0000BEEF) begin n_errors++; $display("FAIL t2_half_unsigned: got %h, want 0000beef", rd); end
    run(1'b0, 1'b1, 2'b10, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL t2_word_ignores_unsigned: got %h, want deadbeef", rd); end
  endtask

  task automatic test_fault();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    logic [31:0] addrs [6] = '{32'h101, 32'h102, 32'h3FF, 32'h400, 32'h3FE, 32'hFFFFFFFC};
    logic [1:0]  sizes [6] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10};
    run(1'b1, 1'b0, 2'b01, 32'h101, 32'h00001234, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL t3_misaligned_store: got %h/%b, want 0/1", rd, er); end
    run(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_errors++; $display("FAIL t3_mem_unchanged: got %h/%b, want deadbeef/0", rd, er); end
    for (int i = 0; i < 6; i++) begin
      run(1'b0, 1'b0, sizes[i], addrs[i], 32'h0, 0, ed, ee, rd, er, lat, st);
      n_checks++;
      if (rd !== ed || er !== ee) begin
        n_errors++; $display("FAIL t3_boundary_%0d @%h: got %h/%b, want %h/%b", i, addrs[i], rd, er, ed, ee);
      end
    end
  endtask

  task automatic test_probe();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    run(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'h00010000 || er !== 1'b0) begin n_errors++; $display("FAIL t4_probe_load: got %h/%b, want 00010000/0", rd, er); end
    run(1'b1, 1'b0, 2'b10, 32'h10, 32'h12345678, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_errors++; $display("FAIL t4_probe_store: got %h/%b, want 0/0", rd, er); end
    run(1'b0, 1'b0, 2'b00, 32'h13, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'h00080000 || er !== 1'b0) begin n_errors++; $display("FAIL t4_probe_unaligned: got %h/%b, want 00080000/0", rd, er); end
    run(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL t4_mem_unchanged: got %h, want deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    run(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 5, ed, ee, rd, er, lat, st);
    n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL t5_hold_stable: got %b, want 1", st); end
    n_checks++; if (lat !== int'(LAT)) begin n_errors++; $display("FAIL t5_latency: got %0d, want %0d", lat, LAT); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL t5_data: got %h, want deadbeef", rd); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    model_txn(1'b0, 1'b0, 2'b10, 32'h104, 32'h0, ed, ee);
    do_txn(1'b0, 1'b0, 2'b10, 32'h104, 32'h0, 2, 1'b1, 32'h300, rd, er, lat, st);
    $display("busy txn load 104 -> rdata=%h err=%0b (store to 300 held during busy)", rd, er);
    n_checks++; if (st !== 1'b1) begin n_errors++; $display("FAIL busy_ready_low: got %b, want 1", st); end
    run(1'b0, 1'b0, 2'b10, 32'h300, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== ed) begin n_errors++; $display("FAIL busy_store_dropped: got %h, want %h", rd, ed); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, rd; logic ee, er; int lat; bit st;
    model_txn(1'b1, 1'b0, 2'b10, 32'h200, 32'hCAFEF00D, ed, ee);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL t6_req_ready: got %b, want 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL t6_resp_valid: got %b, want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_errors++; $display("FAIL t6_resp_data: got %h/%b, want 0/0", resp_rdata, resp_err); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL t6_ready_after_release: got %b, want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL t6_resp_dropped: got %b, want 0", resp_valid); end
    $display("reset pulsed during WAIT of store to 200");
    run(1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL t6_store_kept: got %h, want cafef00d", rd); end
    run(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, ed, ee, rd, er, lat, st);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL t6_old_data_kept: got %h, want deadbeef", rd); end
  endtask

  task automatic test_random();
    logic [31:0] ed, rd, addr; logic ee, er; int lat; bit st;
    logic [1:0] size;
    int sel;
    for (int i = 0; i < 200; i++) begin
      sel  = int'($urandom_range(0, 19));
      size = 2'($urandom_range(0, 2));
      if (sel == 0)      addr = 32'($urandom_range(0, 31));
      else if (sel == 1) addr = 32'($urandom_range(DEPTH - 8, DEPTH + 8));
      else if (sel == 2) addr = $urandom;
      else               addr = 32'($urandom_range(32, DEPTH - 1));
      if (sel >= 3 && (addr % 3) == 0 && $urandom_range(0, 9) == 0) size = 2'b11;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << size) - 32'h1);
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), size, addr, $urandom,
          int'($urandom_range(0, 3)), ed, ee, rd, er, lat, st);
      n_checks++;
      if (rd !== ed || er !== ee) begin
        n_errors++; $display("FAIL rand_%0d_resp @%h: got %h/%b, want %h/%b", i, addr, rd, er, ed, ee);
      end
      n_checks++;
      if (lat !== int'(LAT) || st !== 1'b1) begin
        n_errors++; $display("FAIL rand_%0d_timing: got lat=%0d stable=%b, want lat=%0d stable=1", i, lat, st, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    init_memory();
    test_store_load();
    test_sign_ext();
    test_fault();
    test_probe();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
